// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit accumulation, priced selection with stock check,
// timed dispense phase, single-cycle change return and inactivity timeout. All outputs registered.
module vend_ctrl_multi #(
    parameter int N_ITEMS     = 4,
    parameter int SEL_W       = 2,
    parameter int CREDIT_W    = 8,
    parameter int COIN_W      = 4,
    parameter int IDLE_TO_CYC = 5000,
    parameter int DISP_CYC    = 500
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        coin_valid,
    input  logic [COIN_W-1:0]           coin_value,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        press,
    input  logic                        cancel,
    input  logic [N_ITEMS*CREDIT_W-1:0] price_tbl,
    input  logic [N_ITEMS-1:0]          stock_empty,
    output logic [CREDIT_W-1:0]         credit,
    output logic [1:0]                  state,
    output logic                        run_ind,
    output logic                        hold_ind,
    output logic                        dispense_ind,
    output logic [SEL_W-1:0]            dispense_item,
    output logic                        change_valid,
    output logic [CREDIT_W-1:0]         change_amount,
    output logic                        coin_reject,
    output logic                        err_ind
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CREDIT   = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_REFUND   = 2'd3;

    localparam int IDLE_W = $clog2(IDLE_TO_CYC + 1);
    localparam int DISP_W = $clog2(DISP_CYC + 1);
    localparam int SUM_W  = CREDIT_W + 1;

    logic [1:0]          state_q, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic [CREDIT_W-1:0] change_q, change_n;
    logic [SEL_W-1:0]    item_q, item_n;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_n;
    logic [DISP_W-1:0]   disp_cnt_q, disp_cnt_n;
    logic                run_q, hold_q, dind_q, chv_q, crej_q, err_q;
    logic                crej_n, err_n;
    logic [CREDIT_W-1:0] cha_q;

    logic [CREDIT_W-1:0] price_sel;
    logic                sold_out, sel_ok, buy_ok, overflow;
    logic [SUM_W-1:0]    sum;

    // Selection mux walks only legal indices, so an out-of-range sel simply leaves sel_ok low.
    always_comb begin
        price_sel = '0;
        sold_out  = 1'b0;
        sel_ok    = 1'b0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (sel == SEL_W'(i)) begin
                price_sel = price_tbl[i*CREDIT_W +: CREDIT_W];
                sold_out  = stock_empty[i];
                sel_ok    = 1'b1;
            end
        end
        sum      = {1'b0, credit_q} + SUM_W'(coin_value);
        overflow = sum[CREDIT_W];
        buy_ok   = sel_ok && !sold_out && (credit_q >= price_sel);
    end

    always_comb begin
        state_n    = state_q;
        credit_n   = credit_q;
        change_n   = change_q;
        item_n     = item_q;
        idle_cnt_n = idle_cnt_q;
        disp_cnt_n = disp_cnt_q;
        crej_n     = 1'b0;
        err_n      = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_cnt_n = '0;
                disp_cnt_n = '0;
                if (coin_valid && coin_value != '0) begin
                    credit_n = CREDIT_W'(coin_value);
                    state_n  = S_CREDIT;
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    state_n  = S_REFUND;
                    change_n = credit_q;
                    crej_n   = coin_valid;
                end else if (press && buy_ok) begin
                    state_n    = S_DISPENSE;
                    item_n     = sel;
                    change_n   = credit_q - price_sel;
                    disp_cnt_n = '0;
                    crej_n     = coin_valid;
                end else begin
                    err_n = press;
                    if (coin_valid) begin
                        if (overflow) crej_n = 1'b1;
                        else          credit_n = sum[CREDIT_W-1:0];
                    end
                    // Any coin or press counts as activity; otherwise the timer creeps toward refund.
                    if (press || coin_valid) begin
                        idle_cnt_n = '0;
                    end else if (idle_cnt_q >= IDLE_W'(IDLE_TO_CYC - 1)) begin
                        state_n  = S_REFUND;
                        change_n = credit_q;
                    end else begin
                        idle_cnt_n = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            S_DISPENSE: begin
                crej_n = coin_valid;
                if (disp_cnt_q >= DISP_W'(DISP_CYC - 1)) state_n = S_REFUND;
                else                                     disp_cnt_n = disp_cnt_q + DISP_W'(1);
            end
            S_REFUND: begin
                crej_n     = coin_valid;
                state_n    = S_IDLE;
                credit_n   = '0;
                idle_cnt_n = '0;
                disp_cnt_n = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            change_q   <= '0;
            item_q     <= '0;
            idle_cnt_q <= '0;
            disp_cnt_q <= '0;
            run_q      <= 1'b0;
            hold_q     <= 1'b0;
            dind_q     <= 1'b0;
            chv_q      <= 1'b0;
            cha_q      <= '0;
            crej_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            credit_q   <= credit_n;
            change_q   <= change_n;
            item_q     <= item_n;
            idle_cnt_q <= idle_cnt_n;
            disp_cnt_q <= disp_cnt_n;
            run_q      <= 1'b1;
            hold_q     <= (state_n != S_IDLE);
            dind_q     <= (state_n == S_DISPENSE);
            chv_q      <= (state_n == S_REFUND);
            cha_q      <= (state_n == S_REFUND) ? change_n : '0;
            crej_q     <= crej_n;
            err_q      <= err_n;
        end
    end

    assign state         = state_q;
    assign credit        = credit_q;
    assign run_ind       = run_q;
    assign hold_ind      = hold_q;
    assign dispense_ind  = dind_q;
    assign dispense_item = item_q;
    assign change_valid  = chv_q;
    assign change_amount = cha_q;
    assign coin_reject   = crej_q;
    assign err_ind       = err_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: vector table for per-cycle behaviour,
// plus hand-written overflow and inactivity-timeout sequences.
module tb_vend_ctrl_multi;

    localparam int N_ITEMS = 4, SEL_W = 2, CREDIT_W = 8, COIN_W = 4;
    localparam int IDLE_TO = 40, DISP = 10;

    logic                        clk = 1'b0;
    logic                        reset = 1'b0;
    logic                        coin_valid = 1'b0;
    logic [COIN_W-1:0]           coin_value = '0;
    logic [SEL_W-1:0]            sel = '0;
    logic                        press = 1'b0;
    logic                        cancel = 1'b0;
    logic [N_ITEMS*CREDIT_W-1:0] price_tbl = {8'd20, 8'd5, 8'd6, 8'd4};
    logic [N_ITEMS-1:0]          stock_empty = '0;
    logic [CREDIT_W-1:0]         credit, change_amount;
    logic [1:0]                  state;
    logic                        run_ind, hold_ind, dispense_ind, change_valid, coin_reject, err_ind;
    logic [SEL_W-1:0]            dispense_item;

    int n_cmp = 0;
    int n_bad = 0;

    vend_ctrl_multi #(
        .N_ITEMS(N_ITEMS), .SEL_W(SEL_W), .CREDIT_W(CREDIT_W), .COIN_W(COIN_W),
        .IDLE_TO_CYC(IDLE_TO), .DISP_CYC(DISP)
    ) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel(sel), .press(press), .cancel(cancel), .price_tbl(price_tbl),
        .stock_empty(stock_empty), .credit(credit), .state(state), .run_ind(run_ind),
        .hold_ind(hold_ind), .dispense_ind(dispense_ind), .dispense_item(dispense_item),
        .change_valid(change_valid), .change_amount(change_amount),
        .coin_reject(coin_reject), .err_ind(err_ind)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       cv;
        logic [3:0] cval;
        logic [1:0] s;
        logic       p;
        logic       c;
        logic [3:0] empty;
        int         reps;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected output bundle: state, credit, hold, dispense_ind, item, change_valid, change, reject, err, run.
    function automatic logic [25:0] e(int st, int cr, int hold, int dind, int item,
                                      int chv, int cha, int crej, int err, int run);
        return {2'(st), 8'(cr), 1'(hold), 1'(dind), 2'(item), 1'(chv), 8'(cha),
                1'(crej), 1'(err), 1'(run)};
    endfunction

    function automatic string fmt(logic [25:0] x);
        return $sformatf("st=%0d cr=%0d hold=%0b dind=%0b item=%0d chv=%0b cha=%0d crej=%0b err=%0b run=%0b",
                         x[25:24], x[23:16], x[15], x[14], x[13:12], x[11], x[10:3], x[2], x[1], x[0]);
    endfunction

    function automatic void add(string n, logic rst, logic cv, int cval, int s, logic p, logic c,
                                int empty, int reps, logic [25:0] exp);
        vec_t v;
        v.name = n; v.rst = rst; v.cv = cv; v.cval = 4'(cval); v.s = 2'(s);
        v.p = p; v.c = c; v.empty = 4'(empty); v.reps = reps; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [25:0] exp);
        logic [25:0] act;
        act = {state, credit, hold_ind, dispense_ind, dispense_item, change_valid,
               change_amount, coin_reject, err_ind, run_ind};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic step(input logic cv, input int cval, input int s, input logic p, input logic c);
        coin_valid = cv; coin_value = 4'(cval); sel = 2'(s); press = p; cancel = c;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; coin_value = '0; press = 1'b0; cancel = 1'b0; reset = 1'b0;
    endtask

    initial begin
        //  name            rst cv val sel p  c  empty reps expected
        add("reset",         1, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,0,0,0,0,0,0));
        add("reset_hold",    1, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,0,0,0,0,0,0));
        add("idle",          0, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,0,0,0,0,0,1));
        add("idle_press",    0, 0, 0, 1, 1, 0, 0, 1, e(0,  0,0,0,0,0,0,0,0,1));
        add("idle_cancel",   0, 0, 0, 0, 0, 1, 0, 1, e(0,  0,0,0,0,0,0,0,0,1));
        add("idle_coin0",    0, 1, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,0,0,0,0,0,1));
        add("coin5",         0, 1, 5, 0, 0, 0, 0, 1, e(1,  5,1,0,0,0,0,0,0,1));
        add("coin2",         0, 1, 2, 0, 0, 0, 0, 1, e(1,  7,1,0,0,0,0,0,0,1));
        add("buy_sel1",      0, 0, 0, 1, 1, 0, 0, 1, e(2,  7,1,1,1,0,0,0,0,1));
        add("dispensing",    0, 0, 0, 0, 0, 0, 0, 8, e(2,  7,1,1,1,0,0,0,0,1));
        add("disp_ignore",   0, 0, 0, 0, 1, 1, 0, 1, e(2,  7,1,1,1,0,0,0,0,1));
        add("refund_chg1",   0, 0, 0, 0, 0, 0, 0, 1, e(3,  7,1,0,1,1,1,0,0,1));
        add("back_idle",     0, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,1,0,0,0,0,1));
        add("coin3",         0, 1, 3, 0, 0, 0, 0, 1, e(1,  3,1,0,1,0,0,0,0,1));
        add("short_credit",  0, 0, 0, 0, 1, 0, 0, 1, e(1,  3,1,0,1,0,0,0,1,1));
        add("err_cleared",   0, 0, 0, 0, 0, 0, 0, 1, e(1,  3,1,0,1,0,0,0,0,1));
        add("cancel_chg3",   0, 0, 0, 0, 0, 1, 0, 1, e(3,  3,1,0,1,1,3,0,0,1));
        add("idle2",         0, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,1,0,0,0,0,1));
        add("coin15",        0, 1,15, 0, 0, 0, 4, 1, e(1, 15,1,0,1,0,0,0,0,1));
        add("coin5_to20",    0, 1, 5, 0, 0, 0, 4, 1, e(1, 20,1,0,1,0,0,0,0,1));
        add("sold_out",      0, 0, 0, 2, 1, 0, 4, 1, e(1, 20,1,0,1,0,0,0,1,1));
        add("exact_buy3",    0, 0, 0, 3, 1, 0, 4, 1, e(2, 20,1,1,3,0,0,0,0,1));
        add("dispensing3",   0, 0, 0, 0, 0, 0, 4, 8, e(2, 20,1,1,3,0,0,0,0,1));
        add("disp_coin",     0, 1, 4, 0, 0, 0, 4, 1, e(2, 20,1,1,3,0,0,1,0,1));
        add("refund_zero",   0, 1, 3, 0, 0, 0, 4, 1, e(3, 20,1,0,3,1,0,1,0,1));
        add("idle3",         0, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,3,0,0,0,0,1));
        add("coin9",         0, 1, 9, 0, 0, 0, 0, 1, e(1,  9,1,0,3,0,0,0,0,1));
        add("coin_cancel",   0, 1, 4, 0, 0, 1, 0, 1, e(3,  9,1,0,3,1,9,1,0,1));
        add("idle4",         0, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,3,0,0,0,0,1));
        add("coin6",         0, 1, 6, 0, 0, 0, 0, 1, e(1,  6,1,0,3,0,0,0,0,1));
        add("coin_press",    0, 1, 5, 1, 1, 0, 0, 1, e(2,  6,1,1,1,0,0,1,0,1));
        add("reset_in_disp", 1, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,0,0,0,0,0,0));
        add("after_reset",   0, 0, 0, 0, 0, 0, 0, 1, e(0,  0,0,0,0,0,0,0,0,1));

        #2;
        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].reps; r++) begin
                stock_empty = vecs[k].empty;
                if (r == 0) begin
                    reset = vecs[k].rst;
                    step(vecs[k].cv, int'(vecs[k].cval), int'(vecs[k].s), vecs[k].p, vecs[k].c);
                end else begin
                    step(1'b0, 0, 0, 1'b0, 1'b0);
                end
                check(vecs[k].name, vecs[k].exp);
            end
        end

        // Credit saturation at 250, then inactivity timeout returns everything.
        stock_empty = '0;
        for (int i = 0; i < 16; i++) step(1'b1, 15, 0, 1'b0, 1'b0);
        check("credit240", e(1, 240,1,0,0,0,0,0,0,1));
        step(1'b1, 10, 0, 1'b0, 1'b0);
        check("credit250", e(1, 250,1,0,0,0,0,0,0,1));
        step(1'b1, 8, 0, 1'b0, 1'b0);
        check("overflow_rej", e(1, 250,1,0,0,0,0,1,0,1));
        for (int i = 0; i < IDLE_TO - 1; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
        check("timeout_minus1", e(1, 250,1,0,0,0,0,0,0,1));
        step(1'b0, 0, 0, 1'b0, 1'b0);
        check("timeout_refund", e(3, 250,1,0,0,1,250,0,0,1));
        step(1'b0, 0, 0, 1'b0, 1'b0);
        check("timeout_idle", e(0, 0,0,0,0,0,0,0,0,1));

        // Exactly full-scale credit is accepted; one more unit is refused.
        for (int i = 0; i < 17; i++) step(1'b1, 15, 0, 1'b0, 1'b0);
        check("credit255", e(1, 255,1,0,0,0,0,0,0,1));
        step(1'b1, 1, 0, 1'b0, 1'b0);
        check("overflow_by1", e(1, 255,1,0,0,0,0,1,0,1));
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check("cancel255", e(3, 255,1,0,0,1,255,0,0,1));
        step(1'b0, 0, 0, 1'b0, 1'b0);
        check("idle_final", e(0, 0,0,0,0,0,0,0,0,1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised multi-product vending controller. Accumulates coin credit, accepts a product selection and a buy/cancel request, and holds a dispense phase for a fixed time. It then returns change and goes back to idle. It sits between the coin/keypad input synchronisers and the display/indicator drivers. Compared with the earlier single-product machine it adds N products, a runtime price table, stock-out checking, change computation, an inactivity timeout and credit overflow protection.

Parameters:
N_ITEMS, 4, number of selectable products (≥2)
SEL_W, 2, width of product index; must satisfy 2**SEL_W ≥ N_ITEMS
CREDIT_W, 8, credit/price/change width in currency units
COIN_W, 4, width of one coin value
IDLE_TO_CYC, 5000, inactivity timeout in CREDIT state, in clk cycles
DISP_CYC, 500, dispense phase length, in clk cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
coin_valid  in  1  one-cycle strobe, coin inserted
coin_value  in  COIN_W  value of inserted coin, sampled with coin_valid
sel  in  SEL_W  product index, sampled on press
press  in  1  one-cycle buy request
cancel  in  1  one-cycle cancel request
price_tbl  in  N_ITEMS*CREDIT_W  price of item i at bits [i*CREDIT_W +: CREDIT_W]; static while not in IDLE
stock_empty  in  N_ITEMS  bit i high = item i sold out
credit  out  CREDIT_W  current accumulated credit
state  out  2  IDLE=0, CREDIT=1, DISPENSE=2, REFUND=3
run_ind  out  1  machine operational (high whenever not in reset)
hold_ind  out  1  transaction in progress (CREDIT/DISPENSE/REFUND)
dispense_ind  out  1  high for the whole DISPENSE state
dispense_item  out  SEL_W  latched index of item being dispensed
change_valid  out  1  one-cycle strobe with change_amount
change_amount  out  CREDIT_W  amount returned; 0 when change_valid low
coin_reject  out  1  one-cycle pulse, coin refused
err_ind  out  1  one-cycle pulse: insufficient credit, sold-out item or invalid sel

Behaviour:
- Reset, in the reset cycle and the one following: state=IDLE, credit=0, all strobes/indicators 0, dispense_item=0, timers cleared. run_ind=0 during reset, 1 otherwise.
- All outputs are registered. Each event shows its response on the cycle after its sampling edge.
- IDLE:
  - coin_valid → credit=coin_value, go to CREDIT.
  - press/cancel are ignored; no err_ind.
  - coin_valid with coin_value=0 is ignored.
- CREDIT:
  - coin_valid → credit += coin_value, and the inactivity timer restarts.
  - If the sum would exceed 2**CREDIT_W-1, the coin is not added and coin_reject pulses. coin_reject also pulses in DISPENSE/REFUND for any coin_valid; that coin is never credited.
  - press, valid buy (sel<N_ITEMS, stock_empty[sel]=0, credit ≥ price[sel]): latch dispense_item=sel and change = credit−price[sel], go to DISPENSE.
  - press, otherwise: err_ind pulses, stay in CREDIT, timer restarts.
  - cancel → REFUND with change=credit.
  - Timer reaches IDLE_TO_CYC cycles without coin/press → REFUND.
  - Priority when simultaneous: cancel > press > coin. A coin arriving with a valid press or cancel is rejected (coin_reject).
- DISPENSE:
  - dispense_ind=1 for exactly DISP_CYC cycles, then go to REFUND.
  - press/cancel are ignored.
- REFUND, single cycle:
  - change_valid=1, change_amount=latched change, even when it is 0.
  - credit cleared to 0 on exit; next state IDLE.
- hold_ind = (state≠IDLE). credit output reflects the registered credit; it holds the pre-dispense value during DISPENSE.
- Reset asserted mid-transaction: immediate return to IDLE, credit lost, no change strobe.
- Timers are saturating counters sized by $clog2 of their parameter; no wrap.

Test Plan:
- Reset then insert coins 5, 2 → credit=7, state=CREDIT, hold_ind=1; press sel=1 with price[1]=6 → DISPENSE for DISP_CYC cycles, dispense_item=1, then change_valid with change_amount=1, state=IDLE.
- credit=3, press sel=0 with price=4 → err_ind one cycle, state stays CREDIT, credit=3; cancel → change_amount=3, IDLE.
- stock_empty[2]=1, credit=20, press sel=2 → err_ind, no dispense; press sel=3 (sel<N_ITEMS) with price 20 → DISPENSE, change_amount=0 strobe.
- CREDIT_W=8, credit=250, coin 8 → coin_reject, credit=250; then no activity for IDLE_TO_CYC cycles → REFUND, change_amount=250.
- Same-cycle coin+cancel and coin+valid press → cancel/press wins, coin_reject=1; coin during DISPENSE → coin_reject, credit unchanged.
- Reset pulsed mid-DISPENSE → next cycle state=IDLE, credit=0, dispense_ind=0, no change_valid.
